// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and opcode constants for the immediate encoder
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I     = 2'b00,
    IMM_SHIFT = 2'b01,
    IMM_S     = 2'b10,
    IMM_U     = 2'b11
  } imm_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_EMIT2 = 1'b1
  } state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational field packer and immediate range check
module imm_pack
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  imm_type_e             typ,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  err
);

  logic sext11_ok;
  logic sext31_ok;

  assign sext11_ok = (imm[DATA_WIDTH-1:11] == {(DATA_WIDTH-11){imm[11]}});
  assign sext31_ok = (imm[DATA_WIDTH-1:31] == {(DATA_WIDTH-31){imm[31]}});

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (typ)
      IMM_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !sext11_ok;
      end
      IMM_SHIFT: begin
        inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        err  = (imm[DATA_WIDTH-1:5] != '0);
      end
      IMM_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !sext11_ok;
      end
      default: begin
        inst = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != '0) || !sext31_ok;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - instruction word assembler with LI pseudo-op expansion
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(IMM_TYPE_NUM)-1:0] in_imm_type,
  input  logic                            in_li,
  input  logic [6:0]                      in_opcode,
  input  logic [2:0]                      in_funct3,
  input  logic [6:0]                      in_funct7,
  input  logic [4:0]                      in_rd,
  input  logic [4:0]                      in_rs1,
  input  logic [4:0]                      in_rs2,
  input  logic [DATA_WIDTH-1:0]           in_imm,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INST_WIDTH-1:0]           out_inst,
  output logic                            out_last,
  output logic                            out_range_err
);

  state_e state, state_d;

  logic [INST_WIDTH-1:0] direct_inst, lui_inst, addi_inst;
  logic                  direct_err, lui_err, addi_err;
  logic [19:0]           li_hi;
  logic                  li_err, li_two_beat;
  logic [INST_WIDTH-1:0] pend_inst;
  logic                  pend_err;

  logic                  load, pend_load;
  logic [INST_WIDTH-1:0] ld_inst;
  logic                  ld_last, ld_err;

  // (imm + 0x800) >> 12 only carries out of the low half when imm[11] is set
  assign li_hi       = in_imm[31:12] + {19'b0, in_imm[11]};
  assign li_two_beat = (li_hi != '0) && (in_imm[11:0] != '0);
  // LUI/ADDI sub-encodings are built in range, so their flags stay low
  assign li_err      = (in_imm[DATA_WIDTH-1:31] != {(DATA_WIDTH-31){in_imm[31]}})
                       || lui_err || addi_err;

  imm_pack #(.DATA_WIDTH(DATA_WIDTH), .INST_WIDTH(INST_WIDTH)) u_direct (
    .typ(imm_type_e'(in_imm_type)), .opcode(in_opcode), .funct3(in_funct3),
    .funct7(in_funct7), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .inst(direct_inst), .err(direct_err)
  );

  imm_pack #(.DATA_WIDTH(DATA_WIDTH), .INST_WIDTH(INST_WIDTH)) u_lui (
    .typ(IMM_U), .opcode(OP_LUI), .funct3(3'b000), .funct7(7'b0),
    .rd(in_rd), .rs1(5'd0), .rs2(5'd0),
    .imm({{(DATA_WIDTH-32){li_hi[19]}}, li_hi, 12'b0}),
    .inst(lui_inst), .err(lui_err)
  );

  imm_pack #(.DATA_WIDTH(DATA_WIDTH), .INST_WIDTH(INST_WIDTH)) u_addi (
    .typ(IMM_I), .opcode(li_two_beat ? OP_IMM_32 : OP_IMM), .funct3(3'b000),
    .funct7(7'b0), .rd(in_rd), .rs1(li_two_beat ? in_rd : 5'd0), .rs2(5'd0),
    .imm({{(DATA_WIDTH-12){in_imm[11]}}, in_imm[11:0]}),
    .inst(addi_inst), .err(addi_err)
  );

  assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    pend_load = 1'b0;
    ld_inst   = direct_inst;
    ld_last   = 1'b1;
    ld_err    = direct_err;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          load = 1'b1;
          if (in_li) begin
            ld_err = li_err;
            if (li_two_beat) begin
              ld_inst   = lui_inst;
              ld_last   = 1'b0;
              pend_load = 1'b1;
              state_d   = ST_EMIT2;
            end else begin
              ld_inst = (li_hi == '0) ? addi_inst : lui_inst;
            end
          end
        end
      end
      default: begin
        if (out_valid && out_ready) begin
          load    = 1'b1;
          ld_inst = pend_inst;
          ld_err  = pend_err;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_inst      <= '0;
      out_last      <= 1'b0;
      out_range_err <= 1'b0;
      pend_inst     <= '0;
      pend_err      <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        out_valid     <= 1'b1;
        out_inst      <= ld_inst;
        out_last      <= ld_last;
        out_range_err <= ld_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pend_load) begin
        pend_inst <= addi_inst;
        pend_err  <= li_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed vector bench for imm_encoder
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_type;
  logic        in_li;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_range_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = -1;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_type(in_imm_type), .in_li(in_li), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_last(out_last), .out_range_err(out_range_err)
  );

  typedef struct {
    logic        li;
    logic [1:0]  typ;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    int          beats;
    logic [31:0] inst0, inst1;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_li = v.li; in_imm_type = v.typ; in_opcode = v.opcode; in_funct3 = v.f3;
    in_funct7 = v.f7; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("accept", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    @(negedge clk);
    drive(v);
    wait_ready();
    @(posedge clk); #1 in_valid = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      chk("valid", 64'(out_valid), 64'd1);
      chk("inst", 64'(out_inst), 64'(b == 0 ? v.inst0 : v.inst1));
      chk("last", 64'(out_last), 64'(b == v.beats - 1));
      chk("err", 64'(out_range_err), 64'(v.err));
      if (v.beats == 2 && b == 0) chk("emit2_block", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t mk(input logic li, input logic [1:0] typ, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                              input int beats, input logic [31:0] i0, input logic [31:0] i1,
                              input logic err);
    vec_t v;
    v.li = li; v.typ = typ; v.opcode = op; v.f3 = f3; v.f7 = f7; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.beats = beats; v.inst0 = i0; v.inst1 = i1;
    v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[14];
    vec_t s;
    int   seen;

    vt[0]  = mk(0, 2'b00, 7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'hFFF30293, 32'h0, 0);
    vt[1]  = mk(0, 2'b10, 7'h23, 3'd3, 7'h00, 5'd0, 5'd1, 5'd2, 64'd8,                   1, 32'h0020B423, 32'h0, 0);
    vt[2]  = mk(0, 2'b01, 7'h13, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 64'd5,                   1, 32'h40525213, 32'h0, 0);
    vt[3]  = mk(0, 2'b11, 7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 64'h1234_5000,          1, 32'h123453B7, 32'h0, 0);
    vt[4]  = mk(0, 2'b00, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd2048,                1, 32'h80000093, 32'h0, 1);
    vt[5]  = mk(0, 2'b01, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 64'd32,                  1, 32'h00009093, 32'h0, 1);
    vt[6]  = mk(0, 2'b11, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h1001,                1, 32'h00001037, 32'h0, 1);
    vt[7]  = mk(0, 2'b11, 7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h8000_0000,          1, 32'h80000017, 32'h0, 1);
    vt[8]  = mk(1, 2'b10, 7'h7F, 3'd7, 7'h7F, 5'd10, 5'd31, 5'd31, 64'h1234_5678,       2, 32'h12345537, 32'h6785051B, 0);
    vt[9]  = mk(1, 2'b00, 7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 32'hFFB00093, 32'h0, 0);
    vt[10] = mk(1, 2'b00, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h1_0000_0000,        1, 32'h00000293, 32'h0, 1);
    vt[11] = mk(1, 2'b00, 7'h00, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 64'h7FFF_F800,          2, 32'h800001B7, 32'h8001819B, 0);
    vt[12] = mk(1, 2'b01, 7'h00, 3'd0, 7'h00, 5'd2, 5'd9, 5'd0, 64'h1234_5000,          1, 32'h12345137, 32'h0, 0);
    vt[13] = mk(0, 2'b10, 7'h23, 3'd3, 7'h00, 5'd0, 5'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hFE113E23, 32'h0, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vt[0]); in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(out_range_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cur = i;
      run_vec(vt[i]);
    end

    // back-pressure on both LI beats
    cur = 100;
    @(negedge clk);
    out_ready = 1'b0;
    drive(vt[8]);
    wait_ready();
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall1_valid", 64'(out_valid), 64'd1);
      chk("stall1_inst", 64'(out_inst), 64'h12345537);
      chk("stall1_last", 64'(out_last), 64'd0);
      chk("stall1_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall2_valid", 64'(out_valid), 64'd1);
      chk("stall2_inst", 64'(out_inst), 64'h6785051B);
      chk("stall2_last", 64'(out_last), 64'd1);
      chk("stall2_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_drain_valid", 64'(out_valid), 64'd0);
    chk("stall_drain_in_ready", 64'(in_ready), 64'd1);

    // four back-to-back I-type requests
    cur = 200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_inst", 64'(out_inst), 64'((32'(i - 1) << 20) | (32'(i) << 7) | 32'h13));
        chk("b2b_last", 64'(out_last), 64'd1);
      end
      if (i < 4) begin
        s = mk(0, 2'b00, 7'h13, 3'd0, 7'h00, 5'(i + 1), 5'd0, 5'd0, 64'(i), 1, 32'h0, 32'h0, 0);
        drive(s);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // reset while the ADDIW is pending
    cur = 300;
    @(negedge clk);
    out_ready = 1'b0;
    drive(vt[8]);
    wait_ready();
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("emit2_pre_inst", 64'(out_inst), 64'h12345537);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("emit2_rst_valid", 64'(out_valid), 64'd0);
    chk("emit2_rst_inst", 64'(out_inst), 64'd0);
    chk("emit2_rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("emit2_no_addiw", 64'(seen), 64'd0);
    chk("emit2_idle_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
